mem_port_arbiter: RTL

Round-robin arbiter that shares one single-ported memory between up to four requesters (instruction fetch, load/store, and two spare ports), and drives the 2-bit `selection` of the 4:1 address/data mux in front of that memory. It sits between the pipeline stages that issue memory requests and the `mux_4x1` instances (address, write data, write enable) feeding the memory. It sequences each access over a fixed multi-cycle latency and returns a one-cycle acknowledge to the winning requester.

---
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory among four requesters.
// Sequences a fixed-latency access per grant and returns a one-cycle ack.
module mem_port_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] selection,
  output logic       mem_en,
  output logic [3:0] ack,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  localparam logic [3:0] LOAD = 4'(LATENCY - 1);

  state_t     state, state_n;
  logic [3:0] grant_n, ack_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] sel_n;
  logic [1:0] last, last_n;
  logic [1:0] win, idx;
  logic       hit;

  // Rotating search: last+1, last+2, last+3, then last itself.
  always_comb begin
    win = last;
    hit = 1'b0;
    idx = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!hit && req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      selection <= '0;
      ack       <= '0;
      last      <= 2'd3;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      selection <= sel_n;
      ack       <= ack_n;
      last      <= last_n;
      cnt       <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n   = selection;
    ack_n   = '0;
    last_n  = last;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (hit) begin
          grant_n = 4'b0001 << win;
          sel_n   = win;
          last_n  = win;
          cnt_n   = LOAD;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          ack_n   = grant;
          state_n = ACK;
        end
      end
      ACK: begin
        grant_n = '0;
        state_n = IDLE;
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign mem_en = (state == ACCESS);
  assign busy   = (state != IDLE);

endmodule
